// File: rtl/gfx_dma_queue.sv
// Descriptor FIFO and sequencer that replays queued 8-byte copy descriptors onto the GfxDma register port.
// Optional feature macro GFX_DMA_QUEUE_IRQ_EN adds o_irq_b, asserted low once the queue drains.
module gfx_dma_queue #(
   parameter int DEPTH = 4,
   parameter int TMO   = 15
) (
   input  logic                       i_clk,
   input  logic                       i_rst_b,
   input  logic                       i_cpu_ce_b,
   input  logic                       i_cpu_we_b,
   input  logic [2:0]                 i_cpu_addr,
   input  logic [7:0]                 i_cpu_data,
   output logic                       o_dma_ce_b,
   output logic                       o_dma_we_b,
   output logic [2:0]                 o_dma_addr,
   output logic [7:0]                 o_dma_data,
   input  logic                       i_dma_active,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_full,
   output logic                       o_empty,
   output logic                       o_busy,
   output logic                       o_overflow,
   output logic                       o_done
`ifdef GFX_DMA_QUEUE_IRQ_EN
   ,
   output logic                       o_irq_b
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_DONE} state_t;

   state_t          state;
   logic [2:0]      idx;
   logic            phase;
   logic [3:0]      tmo_cnt;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            overflow;
   logic [63:0]     mem [0:DEPTH-1];
   logic [63:0]     new_entry;
   logic [63:0]     head;
   logic [2:0]      idx_inc;

   logic cpu_wr, flush, push_req, push_ok, pop, busy, full, empty, start;

   assign cpu_wr   = !i_cpu_ce_b && !i_cpu_we_b;
   assign flush    = cpu_wr && (i_cpu_addr == 3'd7) && i_cpu_data[7];
   assign push_req = cpu_wr && (i_cpu_addr == 3'd7) && !i_cpu_data[7];
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign busy     = (state != IDLE);
   assign push_ok  = push_req && !full;
   assign start    = (state == IDLE) && !empty && !i_dma_active && !flush;
   assign idx_inc  = idx + 3'd1;
   assign head     = mem[rd_ptr];

   // Completion is decided combinationally so a one-cycle copy can finish right after LOAD.
   assign pop = !i_dma_active &&
                ((state == WAIT_DONE) || ((state == WAIT_START) && (tmo_cnt == 4'(TMO))));

   for (genvar gi = 0; gi < 7; gi++) begin : g_stage
      logic [7:0] stage_byte;
      always_ff @(posedge i_clk or negedge i_rst_b) begin
         if (!i_rst_b)
            stage_byte <= '0;
         else if (cpu_wr && (i_cpu_addr == 3'(gi)))
            stage_byte <= i_cpu_data;
      end
      assign new_entry[8*gi +: 8] = stage_byte;
   end
   assign new_entry[63:56] = i_cpu_data;

   always_ff @(posedge i_clk) begin
      if (push_ok)
         mem[wr_ptr] <= new_entry;
   end

   always_ff @(posedge i_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         // Keep only the descriptor already on the DMA bus, unless it retires this very cycle.
         rd_ptr   <= rd_ptr + AW'(pop);
         overflow <= 1'b0;
         if (busy && !pop) begin
            wr_ptr <= rd_ptr + PTR_ONE;
            count  <= CNT_ONE;
         end else begin
            wr_ptr <= rd_ptr + AW'(pop);
            count  <= '0;
         end
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
         count <= count + CW'(push_ok) - CW'(pop);
         if (push_req && full) overflow <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         state      <= IDLE;
         idx        <= '0;
         phase      <= 1'b0;
         tmo_cnt    <= '0;
         o_dma_ce_b <= 1'b1;
         o_dma_we_b <= 1'b1;
         o_dma_addr <= '0;
         o_dma_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= LOAD;
                  idx        <= '0;
                  phase      <= 1'b0;
                  o_dma_addr <= '0;
                  o_dma_data <= head[7:0];
               end
            end
            LOAD: begin
               if (!phase) begin
                  phase      <= 1'b1;
                  o_dma_ce_b <= 1'b0;
                  o_dma_we_b <= 1'b0;
               end else begin
                  phase      <= 1'b0;
                  o_dma_ce_b <= 1'b1;
                  o_dma_we_b <= 1'b1;
                  if (idx == 3'd7) begin
                     state   <= WAIT_START;
                     tmo_cnt <= '0;
                  end else begin
                     idx        <= idx_inc;
                     o_dma_addr <= idx_inc;
                     o_dma_data <= head[{idx_inc, 3'b000} +: 8];
                  end
               end
            end
            WAIT_START: begin
               if (i_dma_active)
                  state <= WAIT_DONE;
               else if (pop)
                  state <= IDLE;
               else
                  tmo_cnt <= tmo_cnt + 4'd1;
            end
            WAIT_DONE: begin
               if (!i_dma_active)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef GFX_DMA_QUEUE_IRQ_EN
   always_ff @(posedge i_clk or negedge i_rst_b) begin
      if (!i_rst_b)
         o_irq_b <= 1'b1;
      else if (push_ok || flush)
         o_irq_b <= 1'b1;
      else if (pop && (count == CNT_ONE))
         o_irq_b <= 1'b0;
   end
`endif

   assign o_count    = count;
   assign o_full     = full;
   assign o_empty    = empty;
   assign o_busy     = busy;
   assign o_overflow = overflow;
   assign o_done     = pop;

endmodule

// File: tb/tb_gfx_dma_queue.sv
// Scoreboard bench for gfx_dma_queue: queued descriptors are matched byte by byte against DMA bus writes.
`timescale 1ns/1ps
module tb_gfx_dma_queue;

   logic       clk = 1'b0;
   logic       rst_b = 1'b0;
   logic       cpu_ce_b = 1'b1;
   logic       cpu_we_b = 1'b1;
   logic [2:0] cpu_addr = '0;
   logic [7:0] cpu_data = '0;
   logic       dma_ce_b, dma_we_b;
   logic [2:0] dma_addr;
   logic [7:0] dma_data;
   logic       dma_active;
   logic [2:0] count;
   logic       full, empty, busy, overflow, done;
`ifdef GFX_DMA_QUEUE_IRQ_EN
   logic       irq_b;
`endif

   gfx_dma_queue #(.DEPTH(4), .TMO(15)) dut (
      .i_clk(clk), .i_rst_b(rst_b),
      .i_cpu_ce_b(cpu_ce_b), .i_cpu_we_b(cpu_we_b), .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_data),
      .o_dma_ce_b(dma_ce_b), .o_dma_we_b(dma_we_b), .o_dma_addr(dma_addr), .o_dma_data(dma_data),
      .i_dma_active(dma_active),
      .o_count(count), .o_full(full), .o_empty(empty), .o_busy(busy),
      .o_overflow(overflow), .o_done(done)
`ifdef GFX_DMA_QUEUE_IRQ_EN
      , .o_irq_b(irq_b)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // GfxDma stand-in: a STATE write starts a copy lasting copy_len cycles.
   int busy_left = 0;
   bit dma_auto = 1'b0;
   bit force_hi = 1'b0;
   int copy_len = 3;
   always @(posedge clk) begin
      if (dma_auto && !dma_ce_b && !dma_we_b && dma_addr == 3'd7) busy_left <= copy_len;
      else if (busy_left > 0) busy_left <= busy_left - 1;
   end
   assign dma_active = force_hi || (busy_left > 0);

   // Scoreboard monitor
   logic [63:0] exp_desc[$];
   logic [63:0] mon_e;
   int  mon_idx = 0, n_wr = 0, n_done = 0;
   int  state_cyc = 0, done_cyc = 0, first_cyc = 0, last_wr_cyc = 0;
   bit  prev_low = 1'b0;
   bit  wr_ok;

   always @(negedge clk) begin
      if (rst_b) begin
         if (!dma_ce_b || !dma_we_b) begin
            n_wr++;
            chk("strobe_pair", {62'd0, dma_ce_b, dma_we_b}, 64'd0);
            chk("strobe_width", {63'd0, prev_low}, 64'd0);
            wr_ok = (exp_desc.size() > 0) && (mon_idx < 8);
            chk("wr_expected", {63'd0, wr_ok}, 64'd1);
            if (wr_ok) begin
               mon_e = exp_desc[0];
               chk("wr_addr", {61'd0, dma_addr}, 64'(mon_idx));
               chk("wr_data", {56'd0, dma_data}, {56'd0, mon_e[8*mon_idx +: 8]});
               if (mon_idx == 0) first_cyc = cyc;
               else chk("strobe_period", 64'(cyc - last_wr_cyc), 64'd2);
               if (mon_idx == 7) state_cyc = cyc;
            end
            last_wr_cyc = cyc;
            mon_idx++;
         end
         prev_low = !dma_ce_b || !dma_we_b;
         if (done) begin
            chk("done_bytes", 64'(mon_idx), 64'd8);
            chk("done_expected", {63'd0, exp_desc.size() > 0}, 64'd1);
            if (exp_desc.size() > 0) void'(exp_desc.pop_front());
            mon_idx = 0;
            n_done++;
            done_cyc = cyc;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
      cpu_ce_b = 1'b0; cpu_we_b = 1'b0; cpu_addr = a; cpu_data = d;
      step(1);
      cpu_ce_b = 1'b1; cpu_we_b = 1'b1;
   endtask

   task automatic stage(input logic [63:0] desc);
      for (int i = 0; i < 7; i++) cpu_wr(3'(i), desc[8*i +: 8]);
   endtask

   int push_cyc = 0;
   task automatic push(input logic [63:0] desc, input bit accept);
      cpu_wr(3'd7, desc[63:56]);
      push_cyc = cyc;
      if (accept) exp_desc.push_back(desc);
   endtask

   task automatic wait_done(input int prev, input int limit);
      int k = 0;
      while (n_done <= prev && k < limit) begin step(1); k++; end
      chk("done_seen", {63'd0, n_done > prev}, 64'd1);
   endtask

   function automatic logic [63:0] mk(input int s);
      logic [63:0] r;
      for (int j = 0; j < 7; j++) r[8*j +: 8] = 8'(s * 16 + j * 7 + 1);
      r[63:56] = 8'(s) & 8'h7F;
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int p, nd, w;
      logic [63:0] d1, dk;

      // Reset state
      step(3);
      chk("rst_ce", {63'd0, dma_ce_b}, 64'd1);
      chk("rst_we", {63'd0, dma_we_b}, 64'd1);
      chk("rst_addr_data", {53'd0, dma_addr, dma_data}, 64'd0);
      chk("rst_status", {58'd0, count, empty, full, busy}, {58'd0, 3'd0, 1'b1, 1'b0, 1'b0});
      chk("rst_ovf_done", {62'd0, overflow, done}, 64'd0);
`ifdef GFX_DMA_QUEUE_IRQ_EN
      chk("rst_irq", {63'd0, irq_b}, 64'd1);
`endif
      rst_b = 1'b1;
      step(1);

      // Single descriptor, latency and strobe pattern
      dma_auto = 1'b1; copy_len = 3;
      d1 = {8'h01, 8'hFF, 8'h04, 8'h02, 8'h40, 8'h80, 8'h03, 8'h10};
      stage(d1); push(d1, 1'b1); p = push_cyc;
      chk("t1_count", 64'(count), 64'd1);
      nd = n_done;
      wait_done(nd, 60);
      chk("t1_state_cyc", 64'(state_cyc), 64'(p + 16));
      chk("t1_done_cyc", 64'(done_cyc), 64'(p + 20));
      step(1);
      chk("t1_count_after", 64'(count), 64'd0);
      chk("t1_empty", {63'd0, empty}, 64'd1);
`ifdef GFX_DMA_QUEUE_IRQ_EN
      chk("t1_irq_low", {63'd0, irq_b}, 64'd0);
`endif

      // Full queue held off by an active DMA, then overflow
      force_hi = 1'b1; copy_len = 2;
      w = n_wr;
      for (int i = 0; i < 4; i++) begin stage(mk(i + 1)); push(mk(i + 1), 1'b1); end
`ifdef GFX_DMA_QUEUE_IRQ_EN
      chk("t2_irq_high", {63'd0, irq_b}, 64'd1);
`endif
      chk("t2_full4", {60'd0, count, full}, {60'd0, 3'd4, 1'b1});
      chk("t2_no_ovf", {63'd0, overflow}, 64'd0);
      stage(mk(5)); push(mk(5), 1'b0);
      chk("t2_ovf", {63'd0, overflow}, 64'd1);
      chk("t2_full_after", {60'd0, count, full}, {60'd0, 3'd4, 1'b1});
      chk("t2_idle", {63'd0, busy}, 64'd0);
      chk("t2_no_wr", 64'(n_wr), 64'(w));
      force_hi = 1'b0;
      nd = n_done;
      for (int j = 0; j < 4; j++) wait_done(nd + j, 80);
      step(1);
      chk("t2_drained", 64'(count), 64'd0);

      // Push coinciding with a pop
      copy_len = 10;
      stage(mk(10)); push(mk(10), 1'b1); p = push_cyc;
      stage(mk(11)); push(mk(11), 1'b1);
      stage(mk(12));
      while (cyc < p + 27) step(1);
      chk("t3_done_now", {63'd0, done}, 64'd1);
      chk("t3_count_before", 64'(count), 64'd2);
      nd = n_done;
      push(mk(12), 1'b1);
      chk("t3_count_kept", 64'(count), 64'd2);
      wait_done(nd, 80);
      wait_done(nd + 1, 80);
      step(1);
      chk("t3_drained", 64'(count), 64'd0);

      // Flush while a copy runs
      copy_len = 20;
      stage(mk(13)); push(mk(13), 1'b1); p = push_cyc;
      stage(mk(14)); push(mk(14), 1'b1);
      stage(mk(15)); push(mk(15), 1'b1);
      while (cyc < p + 22) step(1);
      chk("t4_pre", {59'd0, count, overflow, busy}, {59'd0, 3'd3, 1'b1, 1'b1});
      cpu_wr(3'd7, 8'h80);
      while (exp_desc.size() > 1) void'(exp_desc.pop_back());
      chk("t4_post", {59'd0, count, overflow, busy}, {59'd0, 3'd1, 1'b0, 1'b1});
      nd = n_done;
      wait_done(nd, 60);
      step(1);
      chk("t4_empty", {63'd0, empty}, 64'd1);
      w = n_wr;
      step(20);
      chk("t4_no_reload", {31'd0, busy, 32'(n_wr)}, {31'd0, 1'b0, 32'(w)});

      // Start timeout
      dma_auto = 1'b0;
      stage(mk(20)); push(mk(20), 1'b1); p = push_cyc;
      stage(mk(21)); push(mk(21), 1'b1);
      nd = n_done;
      wait_done(nd, 60);
      chk("t5_tmo_cyc", 64'(done_cyc), 64'(p + 32));
      wait_done(nd + 1, 60);
      chk("t5_next_load", 64'(first_cyc), 64'(p + 35));
      step(1);
      chk("t5_drained", 64'(count), 64'd0);

      // Asynchronous reset in the middle of LOAD
      dma_auto = 1'b1; copy_len = 3;
      d1 = mk(30);
      dk = {8'h33, d1[55:0]};
      stage(d1); push(d1, 1'b1); p = push_cyc;
      push(dk, 1'b1);
      while (cyc < p + 8) step(1);
      chk("t6_idx3_strobe", {60'd0, dma_ce_b, dma_addr}, {60'd0, 1'b0, 3'd3});
      #1;
      rst_b = 1'b0; force_hi = 1'b1;
      #1;
      chk("t6_async_strobes", {62'd0, dma_ce_b, dma_we_b}, 64'd3);
      chk("t6_count", {60'd0, count, busy}, 64'd0);
      exp_desc.delete();
      mon_idx = 0;
      prev_low = 1'b0;
      step(2);
      rst_b = 1'b1;
      w = n_wr;
      step(10);
      chk("t6_hold_idle", {31'd0, busy, 32'(n_wr)}, {31'd0, 1'b0, 32'(w)});
      chk("t6_empty", {60'd0, count, empty}, {60'd0, 3'd0, 1'b1});
      force_hi = 1'b0;
      step(3);
      chk("t6_stays_idle", {63'd0, busy}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
